ysyx_24080006_rd_arbiter: RTL and testbench

YSYX_24080006_RD_ARBITER -- requirements
Module: ysyx_24080006_rd_arbiter

---
 rtl/ysyx_24080006_rd_arbiter_if.sv | 24 ++
 rtl/ysyx_24080006_rd_arbiter.sv | 130 +++++++++++++
 tb/tb_ysyx_24080006_rd_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R) between a read master and a read slave.
// Fields are named from the master's point of view.
interface ysyx_24080006_rd_arbiter_if;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/ysyx_24080006_rd_arbiter.sv
// Two-master (IFU/LSU) AXI read arbiter onto one shared downstream read port.
// One burst in flight at a time; AR/R are forwarded combinationally from the grant.
//
// state | meaning
// IDLE  | no burst; grant is latched on the edge any arvalid is seen
// ADDR  | granted AR forwarded downstream, waiting for arready
// DATA  | R beats forwarded to the granted master until rlast handshakes
module ysyx_24080006_rd_arbiter #(
  parameter bit         RR_EN   = 1'b1,
  parameter logic [7:0] MAX_LEN = 8'd15
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_24080006_rd_arbiter_if.slave         ifu_r,
  ysyx_24080006_rd_arbiter_if.slave         lsu_r,
  ysyx_24080006_rd_arbiter_if.master        core_r,
  output logic                              busy,
  output logic                              burst_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e      state_q;
  logic        grant_q;
  logic        last_q;
  logic        busy_q;
  logic        err_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;

  logic        grant_d;
  logic        g_arvalid;
  logic [31:0] g_araddr;
  logic [7:0]  g_arlen;
  logic [2:0]  g_arsize;
  logic [1:0]  g_arburst;
  logic        g_rready;
  logic        in_addr;
  logic        in_data;
  logic        ar_hs;
  logic        r_hs;

  always_comb begin
    g_arvalid = grant_q ? lsu_r.arvalid : ifu_r.arvalid;
    g_araddr  = grant_q ? lsu_r.araddr  : ifu_r.araddr;
    g_arlen   = grant_q ? lsu_r.arlen   : ifu_r.arlen;
    g_arsize  = grant_q ? lsu_r.arsize  : ifu_r.arsize;
    g_arburst = grant_q ? lsu_r.arburst : ifu_r.arburst;
    g_rready  = grant_q ? lsu_r.rready  : ifu_r.rready;
  end

  always_comb begin
    if (ifu_r.arvalid && lsu_r.arvalid) grant_d = RR_EN ? ~last_q : 1'b1;
    else                                grant_d = lsu_r.arvalid;
  end

  // Gating with reset keeps every output at zero while reset is held.
  assign in_addr = !reset && (state_q == ADDR);
  assign in_data = !reset && (state_q == DATA);
  assign ar_hs   = in_addr && g_arvalid && core_r.arready;
  assign r_hs    = in_data && core_r.rvalid && g_rready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_r.arvalid || lsu_r.arvalid) begin
            grant_q <= grant_d;
            state_q <= ADDR;
            busy_q  <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            len_q   <= g_arlen;
            beat_q  <= 8'd0;
            if (g_arlen > MAX_LEN) err_q <= 1'b1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_q <= beat_q + 8'd1;
            if (core_r.rlast) begin
              if (beat_q != len_q) err_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              last_q  <= grant_q;
            end else if (beat_q == len_q) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core_r.arvalid = in_addr && g_arvalid;
  assign core_r.araddr  = in_addr ? g_araddr  : 32'd0;
  assign core_r.arlen   = in_addr ? g_arlen   : 8'd0;
  assign core_r.arsize  = in_addr ? g_arsize  : 3'd0;
  assign core_r.arburst = in_addr ? g_arburst : 2'd0;
  assign core_r.rready  = in_data && g_rready;

  assign ifu_r.arready  = in_addr && !grant_q && core_r.arready;
  assign ifu_r.rvalid   = in_data && !grant_q && core_r.rvalid;
  assign ifu_r.rdata    = (in_data && !grant_q) ? core_r.rdata : 32'd0;
  assign ifu_r.rlast    = in_data && !grant_q && core_r.rlast;

  assign lsu_r.arready  = in_addr && grant_q && core_r.arready;
  assign lsu_r.rvalid   = in_data && grant_q && core_r.rvalid;
  assign lsu_r.rdata    = (in_data && grant_q) ? core_r.rdata : 32'd0;
  assign lsu_r.rlast    = in_data && grant_q && core_r.rlast;

  assign busy      = busy_q && !reset;
  assign burst_err = err_q && !reset;

endmodule

// File: tb/tb_ysyx_24080006_rd_arbiter.sv
// Bench for the IFU/LSU read arbiter: directed scenarios plus randomized bursts
// checked against a transaction-level model of grant order, beat delivery and error flag.
module tb_ysyx_24080006_rd_arbiter;

  logic clock;
  logic reset;
  logic busy, burst_err, busy2, err2;

  ysyx_24080006_rd_arbiter_if ifu_if ();
  ysyx_24080006_rd_arbiter_if lsu_if ();
  ysyx_24080006_rd_arbiter_if core_if ();
  ysyx_24080006_rd_arbiter_if ifu2_if ();
  ysyx_24080006_rd_arbiter_if lsu2_if ();
  ysyx_24080006_rd_arbiter_if core2_if ();

  ysyx_24080006_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_r(ifu_if), .lsu_r(lsu_if), .core_r(core_if),
    .busy(busy), .burst_err(burst_err)
  );

  ysyx_24080006_rd_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .ifu_r(ifu2_if), .lsu_r(lsu2_if), .core_r(core2_if),
    .busy(busy2), .burst_err(err2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int MAX_LEN = 15;

  int          total;
  int          bad;
  bit          pend [2];
  logic [31:0] addr_m [2];
  logic [7:0]  len_m [2];
  int          last_win;
  bit          err_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    ifu_if.arvalid = 0; ifu_if.araddr = 0; ifu_if.arlen = 0; ifu_if.arsize = 0; ifu_if.arburst = 0; ifu_if.rready = 0;
    lsu_if.arvalid = 0; lsu_if.araddr = 0; lsu_if.arlen = 0; lsu_if.arsize = 0; lsu_if.arburst = 0; lsu_if.rready = 0;
    core_if.arready = 0; core_if.rvalid = 0; core_if.rdata = 0; core_if.rlast = 0;
    ifu2_if.arvalid = 0; ifu2_if.araddr = 0; ifu2_if.arlen = 0; ifu2_if.arsize = 0; ifu2_if.arburst = 0; ifu2_if.rready = 0;
    lsu2_if.arvalid = 0; lsu2_if.araddr = 0; lsu2_if.arlen = 0; lsu2_if.arsize = 0; lsu2_if.arburst = 0; lsu2_if.rready = 0;
    core2_if.arready = 0; core2_if.rvalid = 0; core2_if.rdata = 0; core2_if.rlast = 0;
  endtask

  task automatic set_req(input int m, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (m == 0) begin
      ifu_if.arvalid = v; ifu_if.araddr = a; ifu_if.arlen = l; ifu_if.arsize = 3'd2; ifu_if.arburst = 2'b01;
    end else begin
      lsu_if.arvalid = v; lsu_if.araddr = a; lsu_if.arlen = l; lsu_if.arsize = 3'd3; lsu_if.arburst = 2'b01;
    end
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 0) ifu_if.rready = v;
    else        lsu_if.rready = v;
  endtask

  function automatic logic get_arready(input int m);
    return (m == 0) ? ifu_if.arready : lsu_if.arready;
  endfunction

  function automatic logic get_rvalid(input int m);
    return (m == 0) ? ifu_if.rvalid : lsu_if.rvalid;
  endfunction

  function automatic logic [31:0] get_rdata(input int m);
    return (m == 0) ? ifu_if.rdata : lsu_if.rdata;
  endfunction

  function automatic logic get_rlast(input int m);
    return (m == 0) ? ifu_if.rlast : lsu_if.rlast;
  endfunction

  task automatic new_req(input int m);
    addr_m[m] = $urandom;
    len_m[m]  = ($urandom_range(0, 9) == 0) ? 8'(16 + $urandom_range(0, 1)) : 8'($urandom_range(0, 3));
    pend[m]   = 1;
    set_req(m, 1'b1, addr_m[m], len_m[m]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    ifu_if.arvalid = 1; lsu_if.arvalid = 1;
    core_if.arready = 1; core_if.rvalid = 1; core_if.rdata = 32'hFFFF_FFFF; core_if.rlast = 1;
    cyc();
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_burst_err", burst_err, 0);
    chk("rst_core_arvalid", core_if.arvalid, 0);
    chk("rst_core_araddr", core_if.araddr, 0);
    chk("rst_core_rready", core_if.rready, 0);
    chk("rst_ifu_arready", ifu_if.arready, 0);
    chk("rst_ifu_rvalid", ifu_if.rvalid, 0);
    chk("rst_ifu_rdata", ifu_if.rdata, 0);
    chk("rst_lsu_arready", lsu_if.arready, 0);
    chk("rst_lsu_rvalid", lsu_if.rvalid, 0);
    chk("rst_lsu_rlast", lsu_if.rlast, 0);
    clear_inputs();
    reset = 1'b0;
    last_win = 1;
    err_exp  = 0;
    pend[0] = 0; pend[1] = 0;
    cyc();
  endtask

  // Serves one arbitration + burst. Call during an IDLE cycle with requests driven.
  // rl_mode: 0 rlast on beat len, 1 one beat early, 2 one beat late.
  // rmode:   0 random rvalid/rready, 1 rvalid=1 with rready toggling, 2 both held high.
  task automatic serve(input int dly, input int rl_mode, input int rmode,
                       input logic [31:0] dseed, input bit raise_other);
    int w, o, beat, cycles, rlast_at;
    logic rv, rr, lst;
    logic [31:0] d;
    w = (pend[0] && pend[1]) ? (1 - last_win) : (pend[1] ? 1 : 0);
    o = 1 - w;
    rlast_at = int'(len_m[w]);
    if (rl_mode == 1 && rlast_at > 0) rlast_at--;
    else if (rl_mode == 2) rlast_at++;
    #1;
    chk("idle_core_arvalid", core_if.arvalid, 0);
    chk("idle_busy", busy, 0);
    cyc();
    for (int i = 0; i <= dly; i++) begin
      core_if.arready = (i == dly);
      set_rready(w, 1'b1);
      smp();
      chk("addr_busy", busy, 1);
      chk("addr_arvalid", core_if.arvalid, 1);
      chk("addr_araddr", core_if.araddr, addr_m[w]);
      chk("addr_arlen", core_if.arlen, len_m[w]);
      chk("addr_arsize", core_if.arsize, (w == 0) ? 32'd2 : 32'd3);
      chk("addr_arready_win", get_arready(w), (i == dly));
      chk("addr_arready_lose", get_arready(o), 0);
      chk("addr_rready", core_if.rready, 0);
      chk("addr_rvalid_win", get_rvalid(w), 0);
      cyc();
    end
    core_if.arready = 0;
    set_req(w, 1'b0, 32'd0, 8'd0);
    pend[w] = 0;
    if (int'(len_m[w]) > MAX_LEN) err_exp = 1;
    beat = 0;
    cycles = 0;
    while (beat <= rlast_at && cycles < 300) begin
      rv  = (rmode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      rr  = (rmode == 0) ? 1'($urandom_range(0, 1)) : ((rmode == 1) ? (cycles % 2 == 0) : 1'b1);
      d   = (rmode == 0) ? $urandom : dseed + 32'(beat);
      lst = (beat == rlast_at);
      core_if.rvalid = rv; core_if.rdata = d; core_if.rlast = lst;
      set_rready(w, rr);
      set_rready(o, 1'($urandom_range(0, 1)));
      if (raise_other && cycles == 1 && !pend[o]) begin
        pend[o] = 1; addr_m[o] = 32'h3000_1000; len_m[o] = 8'd0;
        set_req(o, 1'b1, addr_m[o], len_m[o]);
      end
      smp();
      chk("data_busy", busy, 1);
      chk("data_core_arvalid", core_if.arvalid, 0);
      chk("data_core_rready", core_if.rready, rr);
      chk("data_rvalid_win", get_rvalid(w), rv);
      if (rv) begin
        chk("data_rdata_win", get_rdata(w), d);
        chk("data_rlast_win", get_rlast(w), lst);
      end
      chk("data_rvalid_lose", get_rvalid(o), 0);
      chk("data_arready_lose", get_arready(o), 0);
      if (rv && rr) begin
        if (lst ? (beat != int'(len_m[w])) : (beat == int'(len_m[w]))) err_exp = 1;
        beat++;
      end
      cycles++;
      cyc();
    end
    chk("data_beats_within_budget", 32'(beat), 32'(rlast_at + 1));
    core_if.rvalid = 0; core_if.rlast = 0; core_if.rdata = 0;
    set_rready(w, 1'b0);
    set_rready(o, 1'b0);
    last_win = w;
    smp();
    chk("ret_busy", busy, 0);
    chk("ret_core_arvalid", core_if.arvalid, 0);
    chk("ret_burst_err", burst_err, err_exp);
  endtask

  initial begin
    int mode;
    total = 0;
    bad = 0;
    reset = 1'b1;
    clear_inputs();
    do_reset();

    // IFU-only single-beat read
    addr_m[0] = 32'h3000_0000; len_m[0] = 8'd0; pend[0] = 1;
    set_req(0, 1'b1, addr_m[0], len_m[0]);
    serve(1, 0, 2, 32'hDEADBEEF, 1'b0);

    // Simultaneous requests from reset, repeated twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      addr_m[0] = 32'h1000_0000 + 32'(r); len_m[0] = 8'd1; pend[0] = 1;
      addr_m[1] = 32'h2000_0000 + 32'(r); len_m[1] = 8'd1; pend[1] = 1;
      set_req(0, 1'b1, addr_m[0], len_m[0]);
      set_req(1, 1'b1, addr_m[1], len_m[1]);
      serve(0, 0, 2, 32'h0000_1000, 1'b0);
      serve(0, 0, 0, 32'h0, 1'b0);
    end

    // Early rlast: sticky error survives later clean bursts, cleared by reset
    addr_m[1] = 32'h4000_0000; len_m[1] = 8'd3; pend[1] = 1;
    set_req(1, 1'b1, addr_m[1], len_m[1]);
    serve(0, 1, 2, 32'h0000_0100, 1'b0);
    addr_m[0] = 32'h4000_1000; len_m[0] = 8'd0; pend[0] = 1;
    set_req(0, 1'b1, addr_m[0], len_m[0]);
    serve(0, 0, 2, 32'h0000_0200, 1'b0);
    do_reset();

    // LSU burst, rready toggling, IFU arrives mid-burst and is served after
    addr_m[1] = 32'h8000_0040; len_m[1] = 8'd3; pend[1] = 1;
    set_req(1, 1'b1, addr_m[1], len_m[1]);
    serve(0, 0, 1, 32'hA000_0000, 1'b1);
    serve(0, 0, 2, 32'hB000_0000, 1'b0);

    // Reset mid-burst after beat 1 of 4
    set_req(1, 1'b1, 32'h5000_0000, 8'd3);
    cyc();
    core_if.arready = 1;
    cyc();
    core_if.arready = 0;
    set_req(1, 1'b0, 32'd0, 8'd0);
    core_if.rvalid = 1; core_if.rdata = 32'h11; lsu_if.rready = 1;
    smp();
    chk("mid_beat0_rvalid", lsu_if.rvalid, 1);
    cyc();
    core_if.rdata = 32'h22;
    smp();
    chk("mid_beat1_rdata", lsu_if.rdata, 32'h22);
    cyc();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lsu_rvalid", lsu_if.rvalid, 0);
    chk("mid_rst_lsu_rdata", lsu_if.rdata, 0);
    chk("mid_rst_core_rready", core_if.rready, 0);
    cyc();
    reset = 1'b0;
    smp();
    chk("mid_after_busy", busy, 0);
    chk("mid_after_lsu_rvalid", lsu_if.rvalid, 0);
    chk("mid_after_core_rready", core_if.rready, 0);
    chk("mid_after_burst_err", burst_err, 0);
    clear_inputs();
    last_win = 1; err_exp = 0; pend[0] = 0; pend[1] = 0;
    addr_m[1] = 32'h5000_0100; len_m[1] = 8'd1; pend[1] = 1;
    set_req(1, 1'b1, addr_m[1], len_m[1]);
    serve(0, 0, 2, 32'hC000_0000, 1'b0);

    // Fixed priority instance: LSU wins every tie
    for (int r = 0; r < 10; r++) begin
      ifu2_if.arvalid = 1; ifu2_if.araddr = 32'h1000 + 32'(r); ifu2_if.arlen = 0;
      lsu2_if.arvalid = 1; lsu2_if.araddr = 32'h2000 + 32'(r); lsu2_if.arlen = 0;
      cyc();
      core2_if.arready = 1;
      smp();
      chk("fp_busy", busy2, 1);
      chk("fp_araddr", core2_if.araddr, 32'h2000 + 32'(r));
      chk("fp_lsu_arready", lsu2_if.arready, 1);
      chk("fp_ifu_arready", ifu2_if.arready, 0);
      cyc();
      core2_if.arready = 0; lsu2_if.arvalid = 0;
      core2_if.rvalid = 1; core2_if.rlast = 1; core2_if.rdata = 32'(r); lsu2_if.rready = 1;
      smp();
      chk("fp_lsu_rvalid", lsu2_if.rvalid, 1);
      chk("fp_ifu_rvalid", ifu2_if.rvalid, 0);
      cyc();
      core2_if.rvalid = 0; core2_if.rlast = 0; lsu2_if.rready = 0;
    end
    ifu2_if.arvalid = 0;
    smp();
    chk("fp_burst_err", err2, 0);

    // Randomized bursts against the transaction model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      for (int m = 0; m < 2; m++) if (!pend[m] && $urandom_range(0, 1) == 1) new_req(m);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      mode = int'($urandom_range(0, 9));
      serve(int'($urandom_range(0, 2)), (mode == 0) ? 1 : ((mode == 1) ? 2 : 0), 0, 32'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
